fantasy_mode_ctrl: RTL

- Output-side controller for the inversion datapath. It debounces the two mode switches and commits a new mode only at a frame boundary, so px_inv selection never changes mid-frame.
- It measures average frame luminance and drives a hysteretic "frame is bright" flag that feeds the inversion mux.
- It sits in the vout clock domain, between the raw switch inputs and the px_inv selection logic.

---
 rtl/fantasy_pkg.sv | 26 ++
 rtl/sw_debounce.sv | 52 +++++
 rtl/fantasy_mode_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fantasy_pkg.sv
// fantasy_pkg: shared types for the fantasy mode controller.
// Holds the committed-mode encoding, the frame FSM states and the reset mode.
package fantasy_pkg;

  typedef enum logic [1:0] {
    MODE_BLK  = 2'b00,
    MODE_PASS = 2'b01,
    MODE_INV  = 2'b10,
    MODE_NBLK = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    WAIT_VS = 2'b00,
    ACCUM   = 2'b01,
    EVAL    = 2'b10
  } state_e;

  localparam mode_e MODE_RST = MODE_PASS;

  // Adaptive block: a committed block mode reports block only on bright frames.
  function automatic mode_e auto_mode(input mode_e sw_mode, input logic bright);
    if (sw_mode == MODE_BLK) return bright ? MODE_BLK : MODE_PASS;
    return sw_mode;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by a saturating stability counter.
// stable_o is high while val_o has been held for DEB_CYCLES synchronised samples.
module sw_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int W          = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] sw_i,
  output logic         stable_o,
  output logic [W-1:0] val_o
);

  localparam int              CNTW    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEB_CYCLES);

  logic [W-1:0]    s1_q, s1_d, s2_q, s2_d, cand_q, cand_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Synchronise, then restart the count whenever the sampled value moves.
  always_comb begin
    s1_d   = sw_i;
    s2_d   = s1_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // State registers; reset makes the candidate 0 with a fresh count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stable_o = (cnt_q == CNT_MAX);
  assign val_o    = cand_q;

endmodule

// File: rtl/fantasy_mode_ctrl.sv
// fantasy_mode_ctrl: frame-aligned mode commit and hysteretic frame brightness.
// Switch changes are debounced and only take effect in the one-cycle EVAL slot
// after a vs rise. Optional macro FANTASY_MODE_AUTO_EN makes block mode follow
// bright_o (reports block on bright frames, pass on dark ones).
module fantasy_mode_ctrl
  import fantasy_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int TH_HI      = 160,
  parameter int TH_LO      = 96,
  parameter int MIN_PIX    = 1024,
  parameter int CW         = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  sw_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [7:0]  gray_i,
  output logic [1:0]  mode_o,
  output logic        bright_o,
  output logic        commit_o,
  output logic [15:0] frame_cnt_o
);

  localparam int            PW        = CW + 8;
  localparam logic [PW-1:0] TH_HI_W   = PW'(TH_HI);
  localparam logic [PW-1:0] TH_LO_W   = PW'(TH_LO);
  localparam logic [CW-1:0] MIN_PIX_W = CW'(MIN_PIX);

  logic       deb_stable;
  logic [1:0] deb_val;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .W(2)) u_deb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sw_i     (sw_i),
    .stable_o (deb_stable),
    .val_o    (deb_val)
  );

  state_e        state_q, state_d;
  logic          vs_q, vs_d;
  logic [CW-1:0] sum_q, sum_d, pix_q, pix_d;
  mode_e         sw_mode_q, sw_mode_d, mode_q, mode_d, pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d, bright_q, bright_d, commit_q, commit_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic          rise;
  logic [CW:0]   sum_add;
  logic [CW-1:0] sum_inc, pix_inc;
  logic [PW-1:0] sum_w, hi_lim, lo_lim;

  // Saturating accumulators and divider-free threshold products at CW+8 bits.
  assign rise    = vs_i & ~vs_q;
  assign sum_add = {1'b0, sum_q} + {{(CW-7){1'b0}}, gray_i};
  assign sum_inc = sum_add[CW] ? '1 : sum_add[CW-1:0];
  assign pix_inc = (&pix_q) ? pix_q : pix_q + CW'(1);
  assign sum_w   = {8'd0, sum_q};
  assign hi_lim  = TH_HI_W * {8'd0, pix_q};
  assign lo_lim  = TH_LO_W * {8'd0, pix_q};

  // Frame FSM, EVAL-slot updates and pending-mode capture.
  always_comb begin
    state_d    = state_q;
    vs_d       = vs_i;
    sum_d      = sum_q;
    pix_d      = pix_q;
    sw_mode_d  = sw_mode_q;
    mode_d     = mode_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bright_d   = bright_q;
    commit_d   = 1'b0;
    fcnt_d     = fcnt_q;
    case (state_q)
      WAIT_VS: if (rise) state_d = ACCUM;
      ACCUM: begin
        if (de_i) begin
          sum_d = sum_inc;
          pix_d = pix_inc;
        end
        if (rise) state_d = EVAL;
      end
      EVAL: begin
        if (pend_vld_q) begin
          sw_mode_d  = pend_q;
          pend_vld_d = 1'b0;
        end
        if (pix_q >= MIN_PIX_W) begin
          if (sum_w >= hi_lim)     bright_d = 1'b1;
          else if (sum_w < lo_lim) bright_d = 1'b0;
        end
`ifdef FANTASY_MODE_AUTO_EN
        mode_d = auto_mode(sw_mode_d, bright_d);
`else
        mode_d = sw_mode_d;
`endif
        commit_d = (mode_d != mode_q);
        fcnt_d   = fcnt_q + 16'd1;
        // The EVAL-cycle pixel opens the new frame.
        sum_d    = de_i ? {{(CW-8){1'b0}}, gray_i} : '0;
        pix_d    = {{(CW-1){1'b0}}, de_i};
        // A back-to-back rise starts an empty frame, which leaves bright_o alone.
        state_d  = rise ? EVAL : ACCUM;
      end
      default: state_d = WAIT_VS;
    endcase
    // Compare against the post-commit value so a just-committed mode is not re-queued;
    // a stable value equal to the committed mode cancels any older pending change.
    if (deb_stable) begin
      if (mode_e'(deb_val) != sw_mode_d) begin
        pend_vld_d = 1'b1;
        pend_d     = mode_e'(deb_val);
      end else begin
        pend_vld_d = 1'b0;
      end
    end
  end

  // Registered state and outputs; reset drops the current frame's statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WAIT_VS;
      vs_q       <= 1'b0;
      sum_q      <= '0;
      pix_q      <= '0;
      sw_mode_q  <= MODE_RST;
      mode_q     <= MODE_RST;
      pend_q     <= MODE_RST;
      pend_vld_q <= 1'b0;
      bright_q   <= 1'b0;
      commit_q   <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      sum_q      <= sum_d;
      pix_q      <= pix_d;
      sw_mode_q  <= sw_mode_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bright_q   <= bright_d;
      commit_q   <= commit_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign mode_o      = mode_q;
  assign bright_o    = bright_q;
  assign commit_o    = commit_q;
  assign frame_cnt_o = fcnt_q;

endmodule
